// File: rtl/mul_pkg.sv
// Shared constants for the sequential 8x8 shift-and-add multiplier.
package mul_pkg;

  localparam int MUL_STEPS = 8;
  localparam int PROD_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_8_add_step.sv
// One add step of the multiplier: ripple-carry 8-bit add of the running high
// half and the gated multiplicand, carry kept as bit 8 of the result.
module mul_8_add_step (
  input  logic [7:0] hi_i,
  input  logic [7:0] addend_i,
  output logic [8:0] sum_o
);

  logic [8:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum_o[i]    = hi_i[i] ^ addend_i[i] ^ carry[i];
    assign carry[i+1]  = (hi_i[i] & addend_i[i]) | (carry[i] & (hi_i[i] ^ addend_i[i]));
  end

  assign sum_o[8] = carry[8];

endmodule

// File: rtl/mul_8_shift_add.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one add/shift per clock.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip the RUN phase.
module mul_8_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_e             state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     step_sum;

  assign addend = lo_q[0] ? mcand_q : '0;

  mul_8_add_step u_add_step (
    .hi_i     (hi_q),
    .addend_i (addend),
    .sum_o    (step_sum)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    product_d = product_q;

    case (state_q)
      ST_RUN: begin
        // Carry lands in hi[7] because the full 9-bit sum shifts in on top.
        {hi_d, lo_d} = {step_sum, lo_q[WIDTH-1:1]};
        count_d      = count_q + 3'd1;
        if (count_q == 3'(MUL_STEPS - 1)) begin
          state_d   = ST_DONE;
          product_d = {step_sum, lo_q[WIDTH-1:1]};
        end
      end
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = 3'd0;
          state_d = ST_RUN;
`ifdef MUL_ZERO_BYPASS_EN
          if ((a == '0) || (b == '0)) begin
            state_d   = ST_DONE;
            product_d = '0;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= 3'd0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Operand/shift registers are always reloaded on an accepted start.
  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
  end

  assign ready   = (state_q != ST_RUN);
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mul_8_shift_add.sv
// Self-checking bench for mul_8_shift_add: directed cases plus random traffic
// compared every cycle against a timer-based reference model.
module tb_mul_8_shift_add;

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int ZLAT = BYPASS ? 1 : 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        ready, busy, done;
  logic [15:0] product;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mul_8_shift_add #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a result appears 8 cycles of busy after acceptance.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [15:0] m_prod = 16'h0;
  logic [15:0] m_pend = 16'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_prod = 16'h0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) m_prod = m_pend;
    end else if (start) begin
      m_pend = {8'h00, a} * {8'h00, b};
      if (BYPASS && (a == 8'h00 || b == 8'h00)) begin
        m_done = 1'b1;
        m_prod = 16'h0;
      end else begin
        m_left = 8;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(m_left == 0));
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("product", 32'(product), 32'(m_prod));
    end
  end

  // Waits for done; the first negedge counted is right after the accepting edge.
  task automatic wait_done(input bit hold, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp, input int lat);
    int n;
    bit ok;
    a = ia; b = ib; start = 1'b1;
    wait_done(1'b0, n, ok);
    check({name, "_seen"}, 32'(ok), 32'd1);
    check({name, "_lat"}, 32'(n), 32'(lat));
    check({name, "_prod"}, 32'(product), 32'(exp));
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int  n, cnt;
    bit  ok;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op("m13x11", 8'd13, 8'd11, 16'h008F, 9);
    run_op("mFFxFF", 8'hFF, 8'hFF, 16'hFE01, 9);

    // Start during RUN must be ignored.
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h03; b = 8'h03; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(1'b0, n, ok);
    check("midrun_lat", 32'(n + 4), 32'd9);
    check("midrun_prod", 32'(product), 32'h03A8);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (done) cnt++; end
    check("midrun_extra_done", 32'(cnt), 32'd0);

    // Back-to-back with start held through DONE.
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(negedge clk); a = 8'd2; b = 8'd5;
    wait_done(1'b1, n, ok);
    check("b2b_first_lat", 32'(n + 1), 32'd9);
    check("b2b_first_prod", 32'(product), 32'h003F);
    wait_done(1'b0, n, ok);
    check("b2b_second_lat", 32'(n), 32'd9);
    check("b2b_second_prod", 32'(product), 32'h000A);
    @(negedge clk);

    // Abort with reset on the 4th RUN cycle.
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'h0);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (done) cnt++; end
    check("abort_no_done", 32'(cnt), 32'd0);

    run_op("m00x77", 8'h00, 8'h77, 16'h0000, ZLAT);
    run_op("mA5x01", 8'hA5, 8'h01, 16'h00A5, 9);
    run_op("m5Cx00", 8'h5C, 8'h00, 16'h0000, ZLAT);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a     = pick();
      b     = pick();
      rst   = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_8_shift_add.md
Name: mul_8_shift_add

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier.
- Performs one 8-bit add-and-shift step per clock and produces a 16-bit product.
- Sits downstream of the 8-bit operand path and time-shares a single 8-bit adder across 8 cycles instead of building an array multiplier.
- Simple start/ready/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand width; only 8 is supported, so product width is 2*WIDTH = 16.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; sampled only when ready=1
- a  input  8  multiplicand, captured on accepted start
- b  input  8  multiplier, captured on accepted start
- ready  output  1  block can accept start (IDLE or DONE)
- busy  output  1  multiplication in progress (RUN)
- done  output  1  one-cycle pulse: product valid
- product  output  16  a*b, held until the next accepted start

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst=1 at an edge) forces IDLE, ready=1, busy=0, done=0, product=16'h0000, count=0. Reset wins over every other input.
- Accepted start: ready=1 and start=1 at an edge. It loads mcand=a, lo=b, hi=0, count=0, and moves to RUN.
- In IDLE with start=0, the block stays in IDLE.
- RUN step, one per edge:
  - {c,s} = hi + (lo[0] ? mcand : 0) with cin=0, as a 9-bit result.
  - {hi,lo} <= {c,s,lo[7:1]}, a 17-bit right shift.
  - count <= count+1.
  - After the 8th step (count was 7), go to DONE.
- Carry out of the 8-bit add is never lost; it becomes hi[7] after the shift.
- DONE lasts exactly one cycle: done=1, ready=1, product={hi,lo}.
  - start=1 in DONE: accepted, new operands load, next state RUN.
  - Otherwise next state IDLE; product stays unchanged.
- Latency: done=1 in the cycle after the 9th rising edge counted from, and including, the accepting edge. Throughput: one result per 9 cycles back-to-back.
- start while busy=1 is ignored; operands are not re-sampled and the in-flight result is unaffected.
- a and b may change freely after acceptance.
- ready = (state!=RUN); busy = (state==RUN); done = (state==DONE). All are registered-state decodes, with no combinational path from start.
- rst asserted mid-RUN aborts the operation: no done pulse, product cleared to 0.
- Boundaries: 0xFF*0xFF=0xFE01 (max, no overflow), x*0=0, x*1=x.

Optional Feature:
- Macro MUL_ZERO_BYPASS_EN.
- Defined: an accepted start with a==0 or b==0 skips RUN and goes directly to DONE on the next edge, with product=0. done is seen one cycle after acceptance; busy never asserts.
- Undefined: zero operands take the full 8-step RUN path; latency is always 9 edges.
- Either way the product value is identical.

Decomposition:
- Shared package/include (mul_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - MUL_STEPS=8
  - product width constant 16
- One natural sub-module, mul_8_add_step: combinational 8-bit add of hi and the gated multiplicand, with 9-bit output {c,s}.
  - Built from per-bit full-adder cells in ripple form, matching the team's existing adder style.
- The top level holds the FSM, counter and shift registers.

Test Plan:
- Reset then a=13, b=11, start one cycle -> busy=1 for 8 cycles, then done pulse with product=16'h008F; ready returns 1.
- a=8'hFF, b=8'hFF -> product=16'hFE01 exactly 9 edges after accept; hi[7] carry path exercised.
- Mid-run start with a=3, b=3 during an 8'h12*8'h34 multiply -> ignored; product=16'h03A8, no extra done.
- start held high across DONE with a=2, b=5 following 7*9 -> first done shows 16'h003F, next done 9 edges later shows 16'h000A, no IDLE cycle.
- rst asserted on the 4th RUN cycle of 8'hAA*8'h55 -> next cycle IDLE, product=0, done never pulses.
- a=0, b=8'h77 -> product=0. With MUL_ZERO_BYPASS_EN: done 1 edge after accept, busy never 1. Without: done 9 edges after accept.
